issue_arbiter: RTL

- Issue-stage arbiter between the reservation-station queues (int, ls, mult, div) and the CDB slot tracker.
- Each cycle it reads the tracker's 7-bit reservation vector and decides which functional-unit classes may issue without a future CDB collision.
- It drives a one-cycle grant back to each queue and the matching issue pulse to the tracker.
- It also enforces the non-pipelined divider's occupancy with an internal busy counter, and round-robins int vs ls, which share one CDB write slot.

---
 rtl/issue_arbiter.sv | 69 ++++++
 1 files changed

// File: rtl/issue_arbiter.sv
`timescale 1ns/1ps
// issue_arbiter: CDB-aware issue arbiter for int/ls/mult/div queues; optional ISSUE_STATS_EN adds issue and CDB-stall counters
module issue_arbiter #(
  parameter int DIV_BUSY_CYCLES = 6,
  parameter int MULT_SLOT = 4,
  parameter int INT_SLOT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       req_int,
  input  logic       req_ls,
  input  logic       req_mult,
  input  logic       req_div,
  input  logic [6:0] cdb_status,
  output logic       grant_int,
  output logic       grant_ls,
  output logic       grant_mult,
  output logic       grant_div,
  output logic       issue_ls_or_int,
  output logic       issue_mult,
  output logic       issue_div,
`ifdef ISSUE_STATS_EN
  output logic [31:0] stat_issues,
  output logic [31:0] stat_cdb_stalls,
`endif
  output logic       div_busy
);
  logic       rr_ptr;
  logic [3:0] div_cnt;
  logic       en;
  logic       il_ok;
  always_comb begin
    en = rst_n && !flush;
    il_ok = en && !cdb_status[INT_SLOT];
    grant_int = il_ok && req_int && (!req_ls || !rr_ptr);
    grant_ls = il_ok && req_ls && (!req_int || rr_ptr);
    grant_mult = en && req_mult && !cdb_status[MULT_SLOT];
    grant_div = en && req_div && div_cnt == 4'd0;
    issue_ls_or_int = grant_int || grant_ls;
    issue_mult = grant_mult;
    issue_div = grant_div;
    div_busy = div_cnt != 4'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr <= 1'b0;
      div_cnt <= 4'd0;
    end else begin
      rr_ptr <= grant_int ? 1'b1 : grant_ls ? 1'b0 : rr_ptr;
      div_cnt <= grant_div ? 4'(DIV_BUSY_CYCLES) : div_busy ? div_cnt - 4'd1 : div_cnt;
    end
`ifdef ISSUE_STATS_EN
  logic [1:0] n_issue;
  logic       stall;
  always_comb begin
    n_issue = {1'b0, issue_ls_or_int} + {1'b0, grant_mult} + {1'b0, grant_div};
    stall = ((req_int || req_ls) && cdb_status[INT_SLOT]) || (req_mult && cdb_status[MULT_SLOT]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_issues <= 32'd0;
      stat_cdb_stalls <= 32'd0;
    end else if (!flush) begin
      stat_issues <= stat_issues + 32'(n_issue);
      stat_cdb_stalls <= stat_cdb_stalls + 32'(stall);
    end
`endif
endmodule
